store_unit: RTL and testbench

- Store-path counterpart to the load-side immediate/data sign extension.
- Accepts a store request from the execute stage: address, rs2 data, funct3 (SB/SH/SW).
- Narrows and replicates data into byte lanes, generates byte strobes and a word-aligned address.
- Drives one write transaction to data memory over a valid/ready handshake, with a response timeout.

---
 rtl/store_unit.sv | 158 +++++++++++++++
 tb/tb_store_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit -- store-path byte-lane formatter and data-memory write master.
//
// Takes one store request (address, rs2 data, funct3) from the execute stage,
// replicates the data into byte lanes, builds byte strobes and a word-aligned
// address, and issues one write to data memory over a valid/ready handshake.
// A store the memory does not accept within TIMEOUT cycles is aborted.
//
// Optional feature: define STORE_MISALIGN_TRAP_EN to reject misaligned SH/SW
// (err pulse, no memory write). Without it, the misaligned low address bits
// are cleared and the store proceeds.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   st_valid/st_ready  request handshake (st_ready high only in IDLE)
//   st_addr, st_data   byte address and rs2 value
//   st_funct3          000=SB, 001=SH, 010=SW, anything else illegal
//   mem_valid/ready    data-memory write handshake
//   mem_addr           word-aligned address
//   mem_wdata          lane-replicated data
//   mem_wstrb          byte enables
//   done, err          one-cycle completion / rejection-or-timeout pulses
//   busy               high whenever the unit is not in IDLE
module store_unit #(
   parameter int width   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             st_valid,
   output logic             st_ready,
   input  logic [width-1:0] st_addr,
   input  logic [width-1:0] st_data,
   input  logic [2:0]       st_funct3,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [width-1:0] mem_addr,
   output logic [width-1:0] mem_wdata,
   output logic [3:0]       mem_wstrb,
   output logic             done,
   output logic             err,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, REQ, FAULT} state_t;

   state_t           state, state_nx;
   logic [7:0]       cnt, cnt_nx;
   logic             mem_valid_nx, done_nx, err_nx;
   logic [width-1:0] mem_addr_nx, mem_wdata_nx;
   logic [3:0]       mem_wstrb_nx;

   // Lane formatting of the incoming request
   logic             lane_legal;
   logic [width-1:0] lane_wdata;
   logic [3:0]       lane_wstrb;

   always_comb begin
      lane_legal = 1'b1;
      lane_wdata = st_data;
      lane_wstrb = 4'b0000;
      case (st_funct3)
         3'b000: begin
            lane_wdata = {4{st_data[7:0]}};
            lane_wstrb = 4'b0001 << st_addr[1:0];
         end
         3'b001: begin
            lane_wdata = {2{st_data[15:0]}};
            lane_wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
            if (st_addr[0]) lane_legal = 1'b0;
`endif
         end
         3'b010: begin
            lane_wdata = st_data;
            lane_wstrb = 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
            if (st_addr[1:0] != 2'b00) lane_legal = 1'b0;
`endif
         end
         default: lane_legal = 1'b0;
      endcase
   end

   assign st_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   // Next-state and registered-output logic
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      mem_valid_nx = mem_valid;
      mem_addr_nx  = mem_addr;
      mem_wdata_nx = mem_wdata;
      mem_wstrb_nx = mem_wstrb;
      done_nx      = 1'b0;
      err_nx       = 1'b0;
      case (state)
         IDLE: begin
            if (st_valid) begin
               mem_addr_nx  = {st_addr[width-1:2], 2'b00};
               mem_wdata_nx = lane_wdata;
               cnt_nx       = 8'd0;
               if (lane_legal) begin
                  mem_wstrb_nx = lane_wstrb;
                  mem_valid_nx = 1'b1;
                  state_nx     = REQ;
               end else begin
                  // err is raised on entry so it is high for the single FAULT cycle
                  mem_wstrb_nx = 4'b0000;
                  err_nx       = 1'b1;
                  state_nx     = FAULT;
               end
            end
         end
         REQ: begin
            // A ready arriving on the last allowed cycle still completes the store
            if (mem_ready) begin
               done_nx      = 1'b1;
               mem_valid_nx = 1'b0;
               cnt_nx       = 8'd0;
               state_nx     = IDLE;
            end else if (cnt == 8'(TIMEOUT - 1)) begin
               err_nx       = 1'b1;
               mem_valid_nx = 1'b0;
               cnt_nx       = 8'd0;
               state_nx     = IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         FAULT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= 4'b0000;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         mem_valid <= mem_valid_nx;
         mem_addr  <= mem_addr_nx;
         mem_wdata <= mem_wdata_nx;
         mem_wstrb <= mem_wstrb_nx;
         done      <= done_nx;
         err       <= err_nx;
      end
   end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_funct3;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        done;
   logic        err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   store_unit #(.width(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .done(done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: what a store should put on the bus
   function automatic bit exp_legal(input logic [31:0] a, input logic [2:0] f);
      if (f > 3'd2) return 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      if (f == 3'd1 && a[0]) return 1'b0;
      if (f == 3'd2 && a % 4 != 0) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f);
      if (f == 3'd0) return (d & 32'hFF) * 32'h01010101;
      if (f == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] exp_wstrb(input logic [31:0] a, input logic [2:0] f);
      int lo;
      lo = a % 4;
      if (f == 3'd0) return 4'(1 << lo);
      if (f == 3'd1) return (lo >= 2) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   // One store; dly = number of REQ cycles with mem_ready low before it rises
   task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f, input int dly);
      bit rdy;
      @(negedge clk);
      chk("idle_ready", st_ready, 1);
      chk("idle_done", done, 0);
      chk("idle_err", err, 0);
      st_valid = 1; st_addr = a; st_data = d; st_funct3 = f;
      mem_ready = (dly == 0);
      @(posedge clk);
      @(negedge clk);
      st_valid = 0; st_addr = $urandom; st_data = $urandom; st_funct3 = 3'($urandom);
      if (!exp_legal(a, f)) begin
         chk("fault_err", err, 1);
         chk("fault_done", done, 0);
         chk("fault_mvalid", mem_valid, 0);
         chk("fault_wstrb", mem_wstrb, 0);
         chk("fault_busy", busy, 1);
         chk("fault_stready", st_ready, 0);
         @(negedge clk);
         chk("fault_err_end", err, 0);
         chk("fault_mvalid_end", mem_valid, 0);
         chk("fault_stready_end", st_ready, 1);
      end else begin
         rdy = 0;
         for (int k = 0; k < TIMEOUT; k++) begin
            mem_ready = (k >= dly);
            rdy = mem_ready;
            chk("req_mvalid", mem_valid, 1);
            chk("req_addr", mem_addr, {a[31:2], 2'b00});
            chk("req_wdata", mem_wdata, exp_wdata(d, f));
            chk("req_wstrb", {28'b0, mem_wstrb}, {28'b0, exp_wstrb(a, f)});
            chk("req_stready", st_ready, 0);
            chk("req_busy", busy, 1);
            chk("req_done", done, 0);
            chk("req_err", err, 0);
            @(negedge clk);
            if (rdy) break;
         end
         chk("end_done", done, rdy);
         chk("end_err", err, !rdy);
         chk("end_mvalid", mem_valid, 0);
         chk("end_stready", st_ready, 1);
         chk("end_busy", busy, 0);
         mem_ready = 0;
      end
   endtask

   initial begin
      rst = 1; st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0; mem_ready = 0;
      repeat (3) @(negedge clk);
      chk("rst_stready", st_ready, 1);
      chk("rst_mvalid", mem_valid, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wstrb", mem_wstrb, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_busy", busy, 0);
      rst = 0;

      // Directed cases
      do_store(32'h1003, 32'hAABBCCDD, 3'b000, 0);
      do_store(32'h2002, 32'h12345678, 3'b001, 0);
      do_store(32'h3000, 32'h12345678, 3'b010, 0);
      do_store(32'h4001, 32'hCAFEF00D, 3'b000, 5);
      do_store(32'h5004, 32'h0BADBEEF, 3'b010, TIMEOUT + 4);
      do_store(32'h6000, 32'h55AA55AA, 3'b001, TIMEOUT - 1);
      do_store(32'h7000, 32'h11111111, 3'b011, 0);
      do_store(32'h3001, 32'h12345678, 3'b010, 0);
      do_store(32'h3003, 32'h87654321, 3'b001, 1);

      // Reset in the middle of a store
      @(negedge clk);
      st_valid = 1; st_addr = 32'h8000; st_data = 32'hDEADBEEF; st_funct3 = 3'b010; mem_ready = 0;
      @(posedge clk);
      @(negedge clk);
      st_valid = 0;
      repeat (2) @(negedge clk);
      chk("midrst_pre_mvalid", mem_valid, 1);
      rst = 1;
      #1;
      chk("midrst_mvalid", mem_valid, 0);
      chk("midrst_stready", st_ready, 1);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      rst = 0;
      do_store(32'h9002, 32'h0000ABCD, 3'b001, 2);

      // Randomized stores
      for (int i = 0; i < 40; i++) begin
         logic [2:0] f;
         int dly;
         f = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         dly = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : int'($urandom_range(0, 5));
         do_store($urandom, $urandom, f, dly);
      end

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
